range_sum_caller: RTL and testbench



---
 rtl/range_sum_caller.sv | 237 +++++++++++++++++++++++
 tb/tb_range_sum_caller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_sum_caller.sv
// -----------------------------------------------------------------------------
// range_sum_caller
//
// Consumer side of the _start/_ready/_valid/_done generator handshake. It takes
// base/limit/step on _start and launches a callee range generator with those
// arguments. It then consumes every value the callee yields and returns one
// result tuple upstream: the signed sum (_0) and the count (_1) of the values.
//
// Ports
//   _clock, _reset        clock and synchronous active-high reset
//   _start, base/limit/step   request and its arguments (sampled in IDLE)
//   _ready                upstream accepts the current result tuple
//   _done, _valid, _0, _1 idle flag and result tuple (sum, count)
//   c_start, c_base/c_limit/c_step   launch pulse and arguments to the callee
//   c_ready               caller accepts callee data
//   c_done, c_valid, c_0  callee status and yielded value
//
// Configuration
//   RANGE_SUM_PARTIAL_EN  when defined, every consumed value also yields a
//                         running (sum, count) tuple through a one-deep output
//                         register with backpressure. The final totals tuple
//                         still follows. Undefined (default): only the single
//                         final tuple is emitted.
// -----------------------------------------------------------------------------
module range_sum_caller #(
   parameter int WIDTH = 32
) (
   input  logic             _clock,
   input  logic             _reset,
   input  logic             _start,
   input  logic             _ready,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] step,
   output logic             _done,
   output logic             _valid,
   output logic [WIDTH-1:0] _0,
   output logic [WIDTH-1:0] _1,
   output logic             c_start,
   output logic             c_ready,
   output logic [WIDTH-1:0] c_base,
   output logic [WIDTH-1:0] c_limit,
   output logic [WIDTH-1:0] c_step,
   input  logic             c_done,
   input  logic             c_valid,
   input  logic [WIDTH-1:0] c_0
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALL  = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,   // partial mode: wait for a free output slot for the totals
      S_EMIT  = 3'd4
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] out0_q, out0_d;
   logic [WIDTH-1:0] out1_q, out1_d;
   logic             c_start_q, c_start_d;
   logic             c_ready_q, c_ready_d;
   logic [WIDTH-1:0] c_base_q, c_base_d;
   logic [WIDTH-1:0] c_limit_q, c_limit_d;
   logic [WIDTH-1:0] c_step_q, c_step_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;

   logic             fire_s;
   logic [WIDTH-1:0] sum_inc_s;
   logic [WIDTH-1:0] cnt_inc_s;

`ifdef RANGE_SUM_PARTIAL_EN
   // The output slot is free when empty or being drained on this edge.
   assign c_ready = c_ready_q && (!valid_q || _ready);
`else
   assign c_ready = c_ready_q;
`endif

   assign fire_s    = c_valid && c_ready;
   assign sum_inc_s = sum_q + c_0;
   assign cnt_inc_s = cnt_q + ONE;

   assign _done   = done_q;
   assign _valid  = valid_q;
   assign _0      = out0_q;
   assign _1      = out1_q;
   assign c_start = c_start_q;
   assign c_base  = c_base_q;
   assign c_limit = c_limit_q;
   assign c_step  = c_step_q;

   // Next-state and next-register computation for the call sequence.
   always_comb begin
      state_d   = state_q;
      done_d    = done_q;
      valid_d   = valid_q;
      out0_d    = out0_q;
      out1_d    = out1_q;
      c_start_d = c_start_q;
      c_ready_d = c_ready_q;
      c_base_d  = c_base_q;
      c_limit_d = c_limit_q;
      c_step_d  = c_step_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            done_d    = 1'b1;
            c_ready_d = 1'b0;
            if (_start) begin
               c_base_d  = base;
               c_limit_d = limit;
               c_step_d  = step;
               sum_d     = {WIDTH{1'b0}};
               cnt_d     = {WIDTH{1'b0}};
               c_start_d = 1'b1;
               done_d    = 1'b0;
               state_d   = S_CALL;
            end else begin
               state_d = S_IDLE;
            end
         end

         // The callee's idle c_done is still high here, so it is not looked at.
         S_CALL: begin
            c_start_d = 1'b0;
            c_ready_d = 1'b1;
            state_d   = S_WAIT;
         end

         S_WAIT: begin
            if (fire_s) begin
               sum_d = sum_inc_s;
               cnt_d = cnt_inc_s;
            end else begin
               sum_d = sum_q;
               cnt_d = cnt_q;
            end
`ifdef RANGE_SUM_PARTIAL_EN
            if (fire_s) begin
               out0_d  = sum_inc_s;
               out1_d  = cnt_inc_s;
               valid_d = 1'b1;
            end else if (valid_q && _ready) begin
               valid_d = 1'b0;
            end else begin
               valid_d = valid_q;
            end
            if (c_done) begin
               c_ready_d = 1'b0;
               state_d   = S_DRAIN;
            end else begin
               state_d = S_WAIT;
            end
`else
            // A value arriving together with c_done is part of the totals.
            if (c_done) begin
               c_ready_d = 1'b0;
               out0_d    = fire_s ? sum_inc_s : sum_q;
               out1_d    = fire_s ? cnt_inc_s : cnt_q;
               valid_d   = 1'b1;
               state_d   = S_EMIT;
            end else begin
               state_d = S_WAIT;
            end
`endif
         end

         // sum_q/cnt_q already hold the totals; load them once the slot frees.
         S_DRAIN: begin
            if (!valid_q || _ready) begin
               out0_d  = sum_q;
               out1_d  = cnt_q;
               valid_d = 1'b1;
               state_d = S_EMIT;
            end else begin
               state_d = S_DRAIN;
            end
         end

         S_EMIT: begin
            if (_ready) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_EMIT;
            end
         end

         default: begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            valid_d   = 1'b0;
            c_start_d = 1'b0;
            c_ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge _clock) begin
      if (_reset) begin
         state_q   <= S_IDLE;
         done_q    <= 1'b1;
         valid_q   <= 1'b0;
         out0_q    <= {WIDTH{1'b0}};
         out1_q    <= {WIDTH{1'b0}};
         c_start_q <= 1'b0;
         c_ready_q <= 1'b0;
         c_base_q  <= {WIDTH{1'b0}};
         c_limit_q <= {WIDTH{1'b0}};
         c_step_q  <= {WIDTH{1'b0}};
         sum_q     <= {WIDTH{1'b0}};
         cnt_q     <= {WIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         out0_q    <= out0_d;
         out1_q    <= out1_d;
         c_start_q <= c_start_d;
         c_ready_q <= c_ready_d;
         c_base_q  <= c_base_d;
         c_limit_q <= c_limit_d;
         c_step_q  <= c_step_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_range_sum_caller.sv
module tb_range_sum_caller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        rdy = 1'b1;
   logic [31:0] base = 32'd0, limit = 32'd0, step = 32'd0;
   logic        done, valid;
   logic [31:0] o0, o1;
   logic        c_start, c_ready;
   logic [31:0] c_base, c_limit, c_step;
   logic        c_done, c_valid;
   logic [31:0] c_0;

   int checks = 0;
   int errors = 0;

   range_sum_caller #(.WIDTH(32)) dut (
      ._clock(clk), ._reset(rst), ._start(start), ._ready(rdy),
      .base(base), .limit(limit), .step(step),
      ._done(done), ._valid(valid), ._0(o0), ._1(o1),
      .c_start(c_start), .c_ready(c_ready),
      .c_base(c_base), .c_limit(c_limit), .c_step(c_step),
      .c_done(c_done), .c_valid(c_valid), .c_0(c_0)
   );

   always #5 clk = ~clk;

   // ---------------- callee range generator model ----------------
   logic               cal_act;
   logic signed [31:0] cal_cur, cal_lim, cal_stp;
   logic               cal_dwl = 1'b0;   // assert c_done together with the last value
   int                 hs_cnt;

   function automatic logic in_rng(input logic signed [31:0] v,
                                   input logic signed [31:0] lim,
                                   input logic signed [31:0] stp);
      if (stp[31]) in_rng = (v > lim);
      else         in_rng = (v < lim);
   endfunction

   assign c_0     = cal_cur;
   assign c_valid = cal_act && in_rng(cal_cur, cal_lim, cal_stp);
   assign c_done  = !cal_act || !in_rng(cal_cur, cal_lim, cal_stp) ||
                    (cal_dwl && !in_rng(cal_cur + cal_stp, cal_lim, cal_stp));

   always @(posedge clk) begin
      if (rst) begin
         cal_act <= 1'b0;
         cal_cur <= 32'sd0;
         cal_lim <= 32'sd0;
         cal_stp <= 32'sd1;
         hs_cnt  <= 0;
      end else if (c_start) begin
         cal_act <= 1'b1;
         cal_cur <= c_base;
         cal_lim <= c_limit;
         cal_stp <= c_step;
         hs_cnt  <= 0;
      end else if (cal_act) begin
         if (c_valid && c_ready) begin
            cal_cur <= cal_cur + cal_stp;
            hs_cnt  <= hs_cnt + 1;
         end
         if (c_done && (!c_valid || c_ready)) cal_act <= 1'b0;
      end
   end

   // ---------------- helpers ----------------
   logic [31:0] got0 [16];
   logic [31:0] got1 [16];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Runs one call; collects every accepted tuple into got0/got1.
   task automatic run_call(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s,
                           input logic dwl, input bit stall,
                           output int ntup, output int first_v);
      bit timed_out;
      for (int i = 0; i < 16; i++) begin
         got0[i] = 32'hFFFF_FFFF;
         got1[i] = 32'hFFFF_FFFF;
      end
      cal_dwl = dwl;
      rdy   = 1'b1;
      base  = b; limit = l; step = s;
      start = 1'b1;
      tick;
      start = 1'b0;
      base  = 32'hDEAD_BEEF; limit = 32'h1234_5678; step = 32'h0;
      chk("c_start_pulse", {31'd0, c_start}, 32'd1);
      chk("busy_done_low", {31'd0, done}, 32'd0);
      chk("c_base", c_base, b);
      chk("c_limit", c_limit, l);
      chk("c_step", c_step, s);
      ntup = 0;
      first_v = -1;
      timed_out = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         tick;
         if (k == 1) begin
            chk("c_ready_on", {30'd0, c_start, c_ready}, 32'd1);
         end
         if (valid && first_v < 0) first_v = k + 1;
         rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (valid && rdy) begin
            if (ntup < 16) begin
               got0[ntup] = o0;
               got1[ntup] = o1;
            end
            ntup++;
         end
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
      if (timed_out) begin
         errors++;
         checks++;
         $display("FAIL call_timeout actual=busy required=done");
      end
      rdy = 1'b1;
   endtask

   typedef struct {
      logic [31:0] b, l, s;
      logic        dwl;
      logic [31:0] e0, e1;
      int          lat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n, fv, last;
      int exp_n;
      bit to;

      vecs[0] = '{b: 32'd0,   l: 32'd10, s: 32'd2,  dwl: 1'b0, e0: 32'd20,         e1: 32'd5,  lat: 0};
      vecs[1] = '{b: 32'd5,   l: 32'd5,  s: 32'd1,  dwl: 1'b0, e0: 32'd0,          e1: 32'd0,  lat: 3};
      vecs[2] = '{b: 32'd10,  l: 32'd0,  s: -32'sd3, dwl: 1'b1, e0: 32'd22,        e1: 32'd4,  lat: 0};
      vecs[3] = '{b: 32'd0,   l: 32'd3,  s: 32'd1,  dwl: 1'b1, e0: 32'd3,          e1: 32'd3,  lat: 0};
      vecs[4] = '{b: -32'sd5, l: 32'd5,  s: 32'd3,  dwl: 1'b1, e0: 32'hFFFF_FFFE,  e1: 32'd4,  lat: 0};
      vecs[5] = '{b: 32'd100, l: 32'd90, s: -32'sd1, dwl: 1'b0, e0: 32'd955,       e1: 32'd10, lat: 0};

      // ---- reset state ----
      rst = 1'b1;
      tick;
      tick;
      chk("rst_done", {31'd0, done}, 32'd1);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_o0", o0, 32'd0);
      chk("rst_o1", o1, 32'd0);
      chk("rst_c_flags", {30'd0, c_start, c_ready}, 32'd0);
      chk("rst_c_args", c_base | c_limit | c_step, 32'd0);
      rst = 1'b0;
      tick;

      // ---- table-driven calls ----
      for (int v = 0; v < 6; v++) begin
         run_call(vecs[v].b, vecs[v].l, vecs[v].s, vecs[v].dwl, 1'b0, n, fv);
`ifdef RANGE_SUM_PARTIAL_EN
         exp_n = int'(vecs[v].e1) + 1;
`else
         exp_n = 1;
`endif
         last = (n > 0 && n <= 16) ? n - 1 : 0;
         chk($sformatf("v%0d_ntuples", v), n, exp_n);
         chk($sformatf("v%0d_sum", v), got0[last], vecs[v].e0);
         chk($sformatf("v%0d_count", v), got1[last], vecs[v].e1);
         chk($sformatf("v%0d_done", v), {31'd0, done}, 32'd1);
         if (vecs[v].lat != 0) chk($sformatf("v%0d_latency", v), fv, vecs[v].lat);
         tick;
      end

`ifndef RANGE_SUM_PARTIAL_EN
      // ---- backpressure in EMIT ----
      cal_dwl = 1'b0;
      rdy = 1'b0;
      base = 32'd0; limit = 32'd10; step = 32'd2; start = 1'b1;
      tick;
      start = 1'b0;
      to = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (valid) begin
            to = 1'b0;
            break;
         end
         tick;
      end
      chk("bp_valid_seen", {31'd0, to}, 32'd0);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("bp_hold%0d", i), {valid, done, 30'd0} ^ o0 ^ (o1 << 8), {1'b1, 1'b0, 30'd0} ^ 32'd20 ^ (32'd5 << 8));
         if (i < 6) tick;
      end
      rdy = 1'b1;
      tick;
      chk("bp_accept", {30'd0, valid, done}, 32'd1);
      tick;
`else
      // ---- per-value tuples with random output stalls ----
      begin
         logic [31:0] pe0 [6];
         logic [31:0] pe1 [6];
         pe0[0] = 32'd0;  pe0[1] = 32'd2; pe0[2] = 32'd6;
         pe0[3] = 32'd12; pe0[4] = 32'd20; pe0[5] = 32'd20;
         pe1[0] = 32'd1;  pe1[1] = 32'd2; pe1[2] = 32'd3;
         pe1[3] = 32'd4;  pe1[4] = 32'd5; pe1[5] = 32'd5;
         run_call(32'd0, 32'd10, 32'd2, 1'b0, 1'b1, n, fv);
         chk("part_ntuples", n, 6);
         for (int i = 0; i < 6; i++) begin
            chk($sformatf("part_t%0d_sum", i), got0[i], pe0[i]);
            chk($sformatf("part_t%0d_cnt", i), got1[i], pe1[i]);
         end
         tick;
      end
`endif

      // ---- reset in the middle of WAIT after two values ----
      cal_dwl = 1'b0;
      rdy = 1'b1;
      base = 32'd0; limit = 32'd10; step = 32'd2; start = 1'b1;
      tick;
      start = 1'b0;
      to = 1'b1;
      for (int k = 0; k < 50; k++) begin
         tick;
         if (hs_cnt == 2) begin
            to = 1'b0;
            break;
         end
      end
      chk("mid_two_values", {31'd0, to}, 32'd0);
      rst = 1'b1;
      tick;
      chk("mid_rst_done", {31'd0, done}, 32'd1);
      chk("mid_rst_valid", {31'd0, valid}, 32'd0);
      chk("mid_rst_out", o0 | o1, 32'd0);
      chk("mid_rst_c_flags", {30'd0, c_start, c_ready}, 32'd0);
      chk("mid_rst_c_args", c_base | c_limit | c_step, 32'd0);
      rst = 1'b0;
      tick;
      run_call(32'd0, 32'd3, 32'd1, 1'b0, 1'b0, n, fv);
      last = (n > 0 && n <= 16) ? n - 1 : 0;
      chk("after_rst_sum", got0[last], 32'd3);
      chk("after_rst_count", got1[last], 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
